// File: rtl/instruction_fetch.sv
// Fetch stage: holds the word-granular PC, drives instruction memory and
// registers {pc, instruction} into IF/ID; resolves JMP locally.
module instruction_fetch #(
    parameter int                     PC_WIDTH  = 32,
    parameter int                     MEM_DEPTH = 100,
    parameter logic [PC_WIDTH-1:0]    RESET_PC  = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_instr,
    input  logic                stall,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_target,
    output logic [31:0]         if_id_instr,
    output logic [PC_WIDTH-1:0] if_id_pc,
    output logic                if_id_valid,
    output logic                fetch_fault
);
    localparam logic [5:0]          OP_JMP   = 6'b101010;
    localparam logic [PC_WIDTH-1:0] DEPTH_PC = PC_WIDTH'(MEM_DEPTH);
    localparam logic [PC_WIDTH-1:0] LAST_PC  = PC_WIDTH'(MEM_DEPTH - 1);

    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_next;
    logic [PC_WIDTH-1:0] jmp_target;
    logic [PC_WIDTH-1:0] if_id_pc_next;
    logic [31:0]         if_id_instr_next;
    logic                if_id_valid_next;
    logic                fetch_fault_next;
    logic                is_jmp;

    assign imem_addr  = pc;
    assign is_jmp     = (imem_instr[31:26] == OP_JMP);
    assign jmp_target = PC_WIDTH'(imem_instr[15:0]);

    // Control contract: redirect outranks stall; stall freezes pc and IF/ID
    // unless redirected. An out-of-range target restarts at RESET_PC and
    // latches fetch_fault until reset.
    always_comb begin
        pc_next          = pc;
        if_id_instr_next = if_id_instr;
        if_id_pc_next    = if_id_pc;
        if_id_valid_next = if_id_valid;
        fetch_fault_next = fetch_fault;
        if (redirect) begin
            if_id_valid_next = 1'b0;
            if (redirect_target >= DEPTH_PC) begin
                pc_next          = RESET_PC;
                fetch_fault_next = 1'b1;
            end else begin
                pc_next = redirect_target;
            end
        end else if (!stall) begin
            if (is_jmp && (jmp_target >= DEPTH_PC)) begin
                pc_next          = RESET_PC;
                if_id_valid_next = 1'b0;
                fetch_fault_next = 1'b1;
            end else begin
                if_id_instr_next = imem_instr;
                if_id_pc_next    = pc;
                if_id_valid_next = 1'b1;
                if (is_jmp)
                    pc_next = jmp_target;
                else if (pc == LAST_PC)
                    pc_next = '0;
                else
                    pc_next = pc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            if_id_instr <= '0;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            pc          <= pc_next;
            if_id_instr <= if_id_instr_next;
            if_id_pc    <= if_id_pc_next;
            if_id_valid <= if_id_valid_next;
            fetch_fault <= fetch_fault_next;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic,
// compared against a transaction-level reference of the fetch rules.
module tb_instruction_fetch;
    localparam int DEPTH = 100;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic        fetch_fault;

    logic [31:0] mem [DEPTH];

    int n_checks;
    int n_pass;

    // reference state
    int          m_pc;
    logic [31:0] m_instr;
    int          m_ipc;
    bit          m_valid;
    bit          m_fault;

    instruction_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_valid     (if_id_valid),
        .fetch_fault     (fetch_fault)
    );

    assign imem_instr = (imem_addr < 32'(DEPTH)) ? mem[imem_addr[6:0]] : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] plain_word();
        logic [5:0] op;
        op = 6'($urandom_range(0, 63));
        if (op == 6'd42) op = 6'd0;
        return {op, 26'($urandom)};
    endfunction

    function automatic logic [31:0] jmp_word(input int target);
        return {6'b101010, 10'($urandom), 16'(target)};
    endfunction

    function automatic logic [31:0] random_word();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return jmp_word($urandom_range(0, 110));
        if (r == 1) return {6'b101000, 26'($urandom)};
        if (r == 2) return {6'b101001, 26'($urandom)};
        return plain_word();
    endfunction

    // Reference: what one clock edge does to the fetch stage, from the rules.
    task automatic model_edge(input bit s, input bit r, input int tgt, input bit rs);
        logic [31:0] w;
        int          t;
        if (rs) begin
            m_pc = 0; m_instr = 0; m_ipc = 0; m_valid = 0; m_fault = 0;
        end else if (r) begin
            m_valid = 0;
            if (tgt >= DEPTH) begin m_pc = 0; m_fault = 1; end
            else m_pc = tgt;
        end else if (!s) begin
            w = mem[m_pc];
            if (w[31:26] == 6'b101010) begin
                t = int'(w[15:0]);
                if (t >= DEPTH) begin
                    m_pc = 0; m_valid = 0; m_fault = 1;
                end else begin
                    m_instr = w; m_ipc = m_pc; m_valid = 1; m_pc = t;
                end
            end else begin
                m_instr = w; m_ipc = m_pc; m_valid = 1;
                m_pc = (m_pc + 1) % DEPTH;
            end
        end
    endtask

    // Drive one cycle's inputs, advance one edge, compare against the model.
    task automatic step(input bit s, input bit r, input int tgt, input bit rs);
        stall = s; redirect = r; redirect_target = 32'(tgt); rst = rs;
        model_edge(s, r, tgt, rs);
        @(posedge clk);
        #1;
        check("imem_addr", imem_addr, 32'(m_pc));
        check("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
        check("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
        if (m_valid || rs) begin
            check("if_id_pc", if_id_pc, 32'(m_ipc));
            check("if_id_instr", if_id_instr, m_instr);
        end
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = plain_word();

        // Reset, then straight-line program
        step(0, 0, 0, 1);
        check("reset_addr", imem_addr, 32'd0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        check("seq_addr5", imem_addr, 32'd5);
        check("seq_pc4", if_id_pc, 32'd4);

        // Stall 3 cycles at pc=5
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        check("stall_hold_addr", imem_addr, 32'd5);
        step(0, 0, 0, 0);
        check("stall_release_pc", if_id_pc, 32'd5);

        // Stall and redirect together: redirect wins
        step(1, 1, 2, 0);
        check("redir_addr", imem_addr, 32'd2);
        check("redir_bubble", {31'b0, if_id_valid}, 32'd0);
        step(0, 0, 0, 0);
        check("redir_pc", if_id_pc, 32'd2);

        // JMP at mem[0] to 3
        mem[0] = jmp_word(3);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        check("jmp_captured", if_id_instr, mem[0]);
        check("jmp_addr", imem_addr, 32'd3);
        step(0, 0, 0, 0);
        check("jmp_next", imem_addr, 32'd4);

        // Wrap at the last word
        step(0, 1, 97, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        check("wrap_addr", imem_addr, 32'd0);
        check("wrap_pc99", if_id_pc, 32'd99);

        // Boundary targets: 99 legal, 100 and 150 faults
        step(0, 1, 99, 0);
        check("tgt99_nofault", {31'b0, fetch_fault}, 32'd0);
        step(0, 1, 150, 0);
        check("fault_set", {31'b0, fetch_fault}, 32'd1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        check("fault_sticky", {31'b0, fetch_fault}, 32'd1);
        step(0, 1, 100, 0);

        // Out-of-range JMP faults too
        step(0, 0, 0, 1);
        mem[0] = jmp_word(100);
        step(0, 0, 0, 0);
        check("jmp_fault", {31'b0, fetch_fault}, 32'd1);
        mem[0] = plain_word();

        // Reset during a stall at pc=7
        step(0, 1, 7, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        check("rst_stall_addr", imem_addr, 32'd0);
        check("rst_stall_fault", {31'b0, fetch_fault}, 32'd0);

        // Random traffic
        for (int i = 0; i < DEPTH; i++) mem[i] = random_word();
        for (int n = 0; n < 3000; n++) begin
            bit s, r, rs;
            int tgt, k;
            s  = ($urandom_range(0, 4) == 0);
            r  = ($urandom_range(0, 7) == 0);
            rs = ($urandom_range(0, 199) == 0);
            k  = $urandom_range(0, 9);
            if (k == 0)      tgt = $urandom_range(100, 300);
            else if (k == 1) tgt = 99;
            else             tgt = $urandom_range(0, 99);
            if (n % 500 == 0) mem[$urandom_range(0, DEPTH - 1)] = random_word();
            step(s, r, tgt, rs);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
